alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station for the integer ALU.
- Buffers decoded ALU instructions from the dispatcher and waits for their source operands via two result-broadcast ports (the ALU's own result and the load/store buffer result).
- Issues one operand-complete instruction per cycle to the ALU as registered operands plus ROB tag.
- Sits between dispatch and the ALU; supports flush on misprediction.

Parameters:
- RS_SIZE_WIDTH, 3, log2 of entry count (8 entries).
- ROB_SIZE_WIDTH, 3, ROB tag width.
- CALC_OP_L1_NUM_WIDTH, 4, primary ALU opcode width.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- need_flush_in  input  1  flush; clears all entries at the edge.
- dispatch_valid_in  input  1  new instruction present this cycle.
- dispatch_op_L1_in  input  CALC_OP_L1_NUM_WIDTH  primary opcode.
- dispatch_op_L2_in  input  1  secondary opcode (add/sub, srl/sra).
- dispatch_vj_in, dispatch_vk_in  input  32 each  operand values, valid when the matching has_q is 0 (immediates arrive in vk).
- dispatch_has_qj_in, dispatch_has_qk_in  input  1 each  operand still pending.
- dispatch_qj_in, dispatch_qk_in  input  ROB_SIZE_WIDTH each  producer tags.
- dispatch_dest_in  input  ROB_SIZE_WIDTH  ROB tag of this instruction.
- alu_ready_in, alu_value_in[31:0], alu_dep_in[ROB_SIZE_WIDTH]  input  ALU result broadcast.
- lsb_ready_in, lsb_value_in[31:0], lsb_dep_in[ROB_SIZE_WIDTH]  input  load/store result broadcast.
- full_out  output  1  all entries busy (combinational from registered busy bits).
- valid_out  output  1  issue strobe to ALU (registered).
- opr1_out, opr2_out  output  32 each  operands (registered).
- dependency_out  output  ROB_SIZE_WIDTH  ROB tag of the issued instruction.
- alu_op_L1_out  output  CALC_OP_L1_NUM_WIDTH  primary opcode.
- alu_op_L2_out  output  1  secondary opcode.

Behaviour:
- Entry fields: busy, op_L1, op_L2, vj, vk, has_qj, has_qk, qj, qk, dest.
- Reset: all busy=0, valid_out=0, all data outputs 0. Reset has priority over rdy_in and flush.
- Priority at each edge: rst_in, then !rdy_in (hold everything), then need_flush_in, then normal operation.
- Flush: all busy cleared, valid_out<=0, any same-cycle dispatch discarded.
- Dispatch handshake:
  - The dispatcher asserts dispatch_valid_in only when full_out=0.
  - A dispatch while full is ignored; no entry is overwritten.
  - The instruction is written to the lowest-index entry that is not busy at the start of the cycle.
  - An entry freed by issue in the same cycle is not reusable until the next cycle.
- Wake-up, every cycle, for each busy entry:
  - If has_qj and qj==alu_dep_in with alu_ready_in, or qj==lsb_dep_in with lsb_ready_in: vj<=that value, has_qj<=0.
  - The same rule applies to qk.
  - If both ports match the same tag, use the ALU value.
  - Tags on operands with has_q=0 are ignored.
- Dispatch bypass: a broadcast in the same cycle as dispatch that matches dispatch_qj_in/qk_in (with has_q set) is captured into the new entry, stored as ready.
- Issue selection:
  - Candidate = busy, has_qj=0, has_qk=0, evaluated on the registered state at the start of the cycle.
  - The lowest-index candidate issues.
  - Next edge: valid_out=1, outputs loaded from the entry, entry busy<=0.
  - With no candidate: valid_out<=0 and data outputs hold.
- Latency:
  - Dispatch with both operands ready to valid_out = 2 edges (write, then issue).
  - Operand woken at edge t: eligible in the following cycle, valid_out at edge t+1.
- Throughput: at most one dispatch and one issue per cycle; both may occur in the same cycle.
- full_out = AND of all busy bits. It is not lowered early by a same-cycle issue.

Test Plan:
- Reset, then dispatch ADD vj=5 vk=7 dest=2, no deps -> valid_out=1 two edges later, opr1=5, opr2=7, dependency_out=2, op_L1=0, op_L2=0; next cycle valid_out=0.
- Dispatch SUB with has_qj=1 qj=4, vk=3 dest=1; three cycles later alu_ready_in=1 alu_dep_in=4 alu_value_in=10 -> valid_out exactly one edge after the broadcast edge, opr1=10, opr2=3, dependency_out=1.
- Dispatch with has_qk=1 qk=6 while lsb_ready_in=1 lsb_dep_in=6 lsb_value_in=0xFFFF_FFFF in the same cycle -> entry captures the value, issues two edges later with opr2=0xFFFF_FFFF.
- Fill 8 ready entries in consecutive cycles, with issue starting after the first -> entries issue in index order with tags matching dispatch order; with issue blocked by deps, full_out=1 after the 8th and a 9th dispatch is dropped.
- 3 busy entries, assert need_flush_in for one cycle with a simultaneous dispatch -> next cycle valid_out=0, full_out=0, no later issue of any old or flushed instruction.
- rdy_in low for 4 cycles with a ready entry pending and broadcasts active -> no issue and no wake-up during the stall; issue resumes one edge after rdy_in returns high.

Source files
------------

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds dispatched ops until both operands
// arrive via the ALU/LSB result broadcasts, then issues one ready op per cycle.
module alu_rs #(
    parameter int RS_SIZE_WIDTH        = 3,
    parameter int ROB_SIZE_WIDTH       = 3,
    parameter int CALC_OP_L1_NUM_WIDTH = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            dispatch_valid_in,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] dispatch_op_L1_in,
    input  logic                            dispatch_op_L2_in,
    input  logic [31:0]                     dispatch_vj_in,
    input  logic [31:0]                     dispatch_vk_in,
    input  logic                            dispatch_has_qj_in,
    input  logic                            dispatch_has_qk_in,
    input  logic [ROB_SIZE_WIDTH-1:0]       dispatch_qj_in,
    input  logic [ROB_SIZE_WIDTH-1:0]       dispatch_qk_in,
    input  logic [ROB_SIZE_WIDTH-1:0]       dispatch_dest_in,
    input  logic                            alu_ready_in,
    input  logic [31:0]                     alu_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0]       alu_dep_in,
    input  logic                            lsb_ready_in,
    input  logic [31:0]                     lsb_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0]       lsb_dep_in,
    output logic                            full_out,
    output logic                            valid_out,
    output logic [31:0]                     opr1_out,
    output logic [31:0]                     opr2_out,
    output logic [ROB_SIZE_WIDTH-1:0]       dependency_out,
    output logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out,
    output logic                            alu_op_L2_out
);

    localparam int unsigned RS_SIZE = 1 << RS_SIZE_WIDTH;

    logic [RS_SIZE-1:0]              busy;
    logic [RS_SIZE-1:0]              ready;
    logic [RS_SIZE-1:0]              op_l2_a;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1_a [RS_SIZE];
    logic [31:0]                     vj_a    [RS_SIZE];
    logic [31:0]                     vk_a    [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0]       dest_a  [RS_SIZE];

    logic                     free_found;
    logic                     issue_found;
    logic [RS_SIZE_WIDTH-1:0] free_idx;
    logic [RS_SIZE_WIDTH-1:0] issue_idx;

    // ALU port wins when both broadcasts carry the same tag.
    function automatic logic bcast_hit(input logic [ROB_SIZE_WIDTH-1:0] tag);
        return (alu_ready_in && tag == alu_dep_in) || (lsb_ready_in && tag == lsb_dep_in);
    endfunction

    function automatic logic [31:0] bcast_val(input logic [ROB_SIZE_WIDTH-1:0] tag);
        return (alu_ready_in && tag == alu_dep_in) ? alu_value_in : lsb_value_in;
    endfunction

    assign full_out = &busy;

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[RS_SIZE_WIDTH'(i)] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RS_SIZE_WIDTH'(i);
            end
            if (ready[RS_SIZE_WIDTH'(i)] && !issue_found) begin
                issue_found = 1'b1;
                issue_idx   = RS_SIZE_WIDTH'(i);
            end
        end
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        logic                            busy_q, has_qj_q, has_qk_q, op_l2_q;
        logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1_q;
        logic [31:0]                     vj_q, vk_q;
        logic [ROB_SIZE_WIDTH-1:0]       qj_q, qk_q, dest_q;
        logic                            sel_wr, sel_iss;

        assign sel_wr  = dispatch_valid_in && free_found && (free_idx == RS_SIZE_WIDTH'(g));
        assign sel_iss = issue_found && (issue_idx == RS_SIZE_WIDTH'(g));

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                busy_q <= 1'b0;
            end else if (rdy_in) begin
                if (need_flush_in) begin
                    busy_q <= 1'b0;
                end else if (sel_wr) begin
                    busy_q   <= 1'b1;
                    op_l1_q  <= dispatch_op_L1_in;
                    op_l2_q  <= dispatch_op_L2_in;
                    dest_q   <= dispatch_dest_in;
                    qj_q     <= dispatch_qj_in;
                    qk_q     <= dispatch_qk_in;
                    if (dispatch_has_qj_in && bcast_hit(dispatch_qj_in)) begin
                        vj_q     <= bcast_val(dispatch_qj_in);
                        has_qj_q <= 1'b0;
                    end else begin
                        vj_q     <= dispatch_vj_in;
                        has_qj_q <= dispatch_has_qj_in;
                    end
                    if (dispatch_has_qk_in && bcast_hit(dispatch_qk_in)) begin
                        vk_q     <= bcast_val(dispatch_qk_in);
                        has_qk_q <= 1'b0;
                    end else begin
                        vk_q     <= dispatch_vk_in;
                        has_qk_q <= dispatch_has_qk_in;
                    end
                end else if (busy_q) begin
                    if (sel_iss) begin
                        busy_q <= 1'b0;
                    end
                    if (has_qj_q && bcast_hit(qj_q)) begin
                        vj_q     <= bcast_val(qj_q);
                        has_qj_q <= 1'b0;
                    end
                    if (has_qk_q && bcast_hit(qk_q)) begin
                        vk_q     <= bcast_val(qk_q);
                        has_qk_q <= 1'b0;
                    end
                end
            end
        end

        assign busy[g]    = busy_q;
        assign ready[g]   = busy_q && !has_qj_q && !has_qk_q;
        assign op_l2_a[g] = op_l2_q;
        assign op_l1_a[g] = op_l1_q;
        assign vj_a[g]    = vj_q;
        assign vk_a[g]    = vk_q;
        assign dest_a[g]  = dest_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out      <= 1'b0;
            opr1_out       <= '0;
            opr2_out       <= '0;
            dependency_out <= '0;
            alu_op_L1_out  <= '0;
            alu_op_L2_out  <= 1'b0;
        end else if (rdy_in) begin
            if (need_flush_in || !issue_found) begin
                valid_out <= 1'b0;
            end else begin
                valid_out      <= 1'b1;
                opr1_out       <= vj_a[issue_idx];
                opr2_out       <= vk_a[issue_idx];
                dependency_out <= dest_a[issue_idx];
                alu_op_L1_out  <= op_l1_a[issue_idx];
                alu_op_L2_out  <= op_l2_a[issue_idx];
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs with a cycle-level behavioural model of the
// reservation station compared against the DUT after every clock edge.
module tb_alu_rs;

    localparam int RSW = 3;
    localparam int RW  = 3;
    localparam int OPW = 4;
    localparam int N   = 1 << RSW;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, need_flush_in;
    logic            dispatch_valid_in, dispatch_op_L2_in;
    logic [OPW-1:0]  dispatch_op_L1_in;
    logic [31:0]     dispatch_vj_in, dispatch_vk_in;
    logic            dispatch_has_qj_in, dispatch_has_qk_in;
    logic [RW-1:0]   dispatch_qj_in, dispatch_qk_in, dispatch_dest_in;
    logic            alu_ready_in, lsb_ready_in;
    logic [31:0]     alu_value_in, lsb_value_in;
    logic [RW-1:0]   alu_dep_in, lsb_dep_in;
    logic            full_out, valid_out, alu_op_L2_out;
    logic [31:0]     opr1_out, opr2_out;
    logic [RW-1:0]   dependency_out;
    logic [OPW-1:0]  alu_op_L1_out;

    alu_rs #(
        .RS_SIZE_WIDTH(RSW),
        .ROB_SIZE_WIDTH(RW),
        .CALC_OP_L1_NUM_WIDTH(OPW)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .need_flush_in(need_flush_in),
        .dispatch_valid_in(dispatch_valid_in),
        .dispatch_op_L1_in(dispatch_op_L1_in),
        .dispatch_op_L2_in(dispatch_op_L2_in),
        .dispatch_vj_in(dispatch_vj_in),
        .dispatch_vk_in(dispatch_vk_in),
        .dispatch_has_qj_in(dispatch_has_qj_in),
        .dispatch_has_qk_in(dispatch_has_qk_in),
        .dispatch_qj_in(dispatch_qj_in),
        .dispatch_qk_in(dispatch_qk_in),
        .dispatch_dest_in(dispatch_dest_in),
        .alu_ready_in(alu_ready_in),
        .alu_value_in(alu_value_in),
        .alu_dep_in(alu_dep_in),
        .lsb_ready_in(lsb_ready_in),
        .lsb_value_in(lsb_value_in),
        .lsb_dep_in(lsb_dep_in),
        .full_out(full_out),
        .valid_out(valid_out),
        .opr1_out(opr1_out),
        .opr2_out(opr2_out),
        .dependency_out(dependency_out),
        .alu_op_L1_out(alu_op_L1_out),
        .alu_op_L2_out(alu_op_L2_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic           busy;
        logic [OPW-1:0] op1;
        logic           op2;
        logic [31:0]    vj, vk;
        logic           hj, hk;
        logic [RW-1:0]  qj, qk, dest;
    } ent_t;

    ent_t           m [N];
    logic           m_valid, m_op2, m_full;
    logic [31:0]    m_o1, m_o2;
    logic [RW-1:0]  m_dep;
    logic [OPW-1:0] m_op1;
    bit             live = 1'b0;
    int             n_vec = 0;
    int             n_err = 0;
    int             got [$];

    // Result bus lookup: returns 1 with the value if either port carries tag.
    function automatic bit snoop(input logic [RW-1:0] tag, output logic [31:0] v);
        v = '0;
        if (alu_ready_in && alu_dep_in == tag) begin v = alu_value_in; return 1'b1; end
        if (lsb_ready_in && lsb_dep_in == tag) begin v = lsb_value_in; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_step();
        ent_t        old [N];
        int          fi, ii;
        logic [31:0] v;
        if (rst_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_valid = 1'b0; m_o1 = '0; m_o2 = '0; m_dep = '0; m_op1 = '0; m_op2 = 1'b0;
            live = 1'b1;
            return;
        end
        if (!rdy_in) return;
        if (need_flush_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_valid = 1'b0;
            return;
        end
        old = m;
        fi = -1;
        ii = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (!old[i].busy) fi = i;
            if (old[i].busy && !old[i].hj && !old[i].hk) ii = i;
        end
        for (int i = 0; i < N; i++) begin
            if (old[i].busy) begin
                if (old[i].hj && snoop(old[i].qj, v)) begin m[i].vj = v; m[i].hj = 1'b0; end
                if (old[i].hk && snoop(old[i].qk, v)) begin m[i].vk = v; m[i].hk = 1'b0; end
            end
        end
        if (ii >= 0) begin
            m_valid = 1'b1;
            m_o1 = old[ii].vj; m_o2 = old[ii].vk; m_dep = old[ii].dest;
            m_op1 = old[ii].op1; m_op2 = old[ii].op2;
            m[ii].busy = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        if (dispatch_valid_in && fi >= 0) begin
            m[fi].busy = 1'b1;
            m[fi].op1 = dispatch_op_L1_in; m[fi].op2 = dispatch_op_L2_in;
            m[fi].vj = dispatch_vj_in; m[fi].vk = dispatch_vk_in;
            m[fi].hj = dispatch_has_qj_in; m[fi].hk = dispatch_has_qk_in;
            m[fi].qj = dispatch_qj_in; m[fi].qk = dispatch_qk_in;
            m[fi].dest = dispatch_dest_in;
            if (dispatch_has_qj_in && snoop(dispatch_qj_in, v)) begin m[fi].vj = v; m[fi].hj = 1'b0; end
            if (dispatch_has_qk_in && snoop(dispatch_qk_in, v)) begin m[fi].vk = v; m[fi].hk = 1'b0; end
        end
    endtask

    always @(posedge clk_in) begin
        model_step();
        #1;
        if (live) begin
            m_full = 1'b1;
            foreach (m[i]) if (!m[i].busy) m_full = 1'b0;
            n_vec++;
            if ({valid_out, full_out, opr1_out, opr2_out, dependency_out, alu_op_L1_out, alu_op_L2_out}
                !== {m_valid, m_full, m_o1, m_o2, m_dep, m_op1, m_op2}) begin
                n_err++;
                $display("FAIL model_cmp t=%0t valid/full/opr1/opr2/dep/op1/op2 got %b/%b/%h/%h/%0d/%0d/%b expected %b/%b/%h/%h/%0d/%0d/%b",
                         $time, valid_out, full_out, opr1_out, opr2_out, dependency_out, alu_op_L1_out, alu_op_L2_out,
                         m_valid, m_full, m_o1, m_o2, m_dep, m_op1, m_op2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic rec();
        if (valid_out === 1'b1) got.push_back(int'(dependency_out));
    endtask

    task automatic clr();
        dispatch_valid_in = 1'b0; dispatch_op_L1_in = '0; dispatch_op_L2_in = 1'b0;
        dispatch_vj_in = '0; dispatch_vk_in = '0;
        dispatch_has_qj_in = 1'b0; dispatch_has_qk_in = 1'b0;
        dispatch_qj_in = '0; dispatch_qk_in = '0; dispatch_dest_in = '0;
        alu_ready_in = 1'b0; alu_value_in = '0; alu_dep_in = '0;
        lsb_ready_in = 1'b0; lsb_value_in = '0; lsb_dep_in = '0;
        need_flush_in = 1'b0;
    endtask

    task automatic disp(input logic [OPW-1:0] op1, input logic op2, input logic [31:0] vj, input logic [31:0] vk,
                        input logic hj, input logic hk, input logic [RW-1:0] qj, input logic [RW-1:0] qk,
                        input logic [RW-1:0] dest);
        dispatch_valid_in = 1'b1; dispatch_op_L1_in = op1; dispatch_op_L2_in = op2;
        dispatch_vj_in = vj; dispatch_vk_in = vk;
        dispatch_has_qj_in = hj; dispatch_has_qk_in = hk;
        dispatch_qj_in = qj; dispatch_qk_in = qk; dispatch_dest_in = dest;
    endtask

    task automatic chk_order(input string name, input int count);
        chk({name, "_count"}, 32'(got.size()), 32'(count));
        for (int i = 0; i < got.size() && i < count; i++) chk({name, "_tag"}, 32'(got[i]), 32'(i));
    endtask

    initial begin
        clr();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        repeat (2) cyc();
        rst_in = 1'b0;
        chk("reset_valid", 32'(valid_out), 0);
        chk("reset_full", 32'(full_out), 0);
        chk("reset_opr1", opr1_out, 0);
        chk("reset_dep", 32'(dependency_out), 0);

        // ADD 5 + 7 -> tag 2, two edges from dispatch
        disp(4'd0, 1'b0, 32'd5, 32'd7, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2);
        cyc(); clr();
        chk("add_not_yet", 32'(valid_out), 0);
        cyc();
        chk("add_valid", 32'(valid_out), 1);
        chk("add_opr1", opr1_out, 32'd5);
        chk("add_opr2", opr2_out, 32'd7);
        chk("add_dep", 32'(dependency_out), 2);
        chk("add_op1", 32'(alu_op_L1_out), 0);
        chk("add_op2", 32'(alu_op_L2_out), 0);
        cyc();
        chk("add_drop", 32'(valid_out), 0);

        // SUB waiting on tag 4, woken by ALU broadcast three cycles later
        disp(4'd0, 1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b0, 3'd4, 3'd0, 3'd1);
        cyc(); clr();
        cyc(); cyc();
        alu_ready_in = 1'b1; alu_dep_in = 3'd4; alu_value_in = 32'd10;
        cyc(); clr();
        chk("sub_wake_edge", 32'(valid_out), 0);
        cyc();
        chk("sub_valid", 32'(valid_out), 1);
        chk("sub_opr1", opr1_out, 32'd10);
        chk("sub_opr2", opr2_out, 32'd3);
        chk("sub_dep", 32'(dependency_out), 1);
        chk("sub_op2", 32'(alu_op_L2_out), 1);

        // Dispatch-cycle bypass from the LSB port
        disp(4'd2, 1'b0, 32'd9, 32'd0, 1'b0, 1'b1, 3'd0, 3'd6, 3'd3);
        lsb_ready_in = 1'b1; lsb_dep_in = 3'd6; lsb_value_in = 32'hFFFF_FFFF;
        cyc(); clr();
        chk("byp_not_yet", 32'(valid_out), 0);
        cyc();
        chk("byp_valid", 32'(valid_out), 1);
        chk("byp_opr2", opr2_out, 32'hFFFF_FFFF);
        chk("byp_opr1", opr1_out, 32'd9);
        chk("byp_dep", 32'(dependency_out), 3);
        repeat (3) cyc();

        // Eight ready dispatches back to back: issue order follows tags
        got.delete();
        for (int i = 0; i < N; i++) begin
            disp(4'(i), 1'b0, 32'(i * 16), 32'(i), 1'b0, 1'b0, 3'd0, 3'd0, 3'(i));
            cyc(); rec();
        end
        clr();
        repeat (4) begin cyc(); rec(); end
        chk_order("stream", N);

        // Fill with blocked entries, ninth dispatch dropped, then release all
        for (int i = 0; i < N; i++) begin
            disp(4'd1, 1'b0, 32'd0, 32'(i), 1'b1, 1'b0, 3'd7, 3'd0, 3'(i));
            cyc();
        end
        chk("fill_full", 32'(full_out), 1);
        disp(4'd1, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5);
        cyc(); clr();
        chk("fill_full_hold", 32'(full_out), 1);
        chk("fill_no_issue", 32'(valid_out), 0);
        alu_ready_in = 1'b1; alu_dep_in = 3'd7; alu_value_in = 32'h100;
        cyc(); clr();
        got.delete();
        repeat (10) begin cyc(); rec(); end
        chk_order("release", N);
        chk("release_opr1", opr1_out, 32'h100);

        // Flush with three blocked entries and a simultaneous ready dispatch
        for (int i = 0; i < 3; i++) begin
            disp(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 3'd6, 3'd0, 3'(i));
            cyc();
        end
        disp(4'd0, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7);
        need_flush_in = 1'b1;
        cyc(); clr();
        chk("flush_valid", 32'(valid_out), 0);
        chk("flush_full", 32'(full_out), 0);
        alu_ready_in = 1'b1; alu_dep_in = 3'd6; alu_value_in = 32'd1;
        cyc(); clr();
        got.delete();
        repeat (6) begin cyc(); rec(); end
        chk("flush_no_issue", 32'(got.size()), 0);

        // Stall: nothing moves while rdy_in is low, broadcasts are ignored
        disp(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 3'd2, 3'd0, 3'd5);
        cyc();
        disp(4'd3, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4);
        cyc(); clr();
        rdy_in = 1'b0;
        alu_ready_in = 1'b1; alu_dep_in = 3'd2; alu_value_in = 32'h55;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_valid", 32'(valid_out), 0);
        end
        rdy_in = 1'b1;
        clr();
        cyc();
        chk("resume_valid", 32'(valid_out), 1);
        chk("resume_dep", 32'(dependency_out), 4);
        chk("resume_opr1", opr1_out, 32'h11);
        got.delete();
        repeat (4) begin cyc(); rec(); end
        chk("stall_no_wake", 32'(got.size()), 0);
        alu_ready_in = 1'b1; alu_dep_in = 3'd2; alu_value_in = 32'h55;
        cyc(); clr();
        chk("late_wake_edge", 32'(valid_out), 0);
        cyc();
        chk("late_valid", 32'(valid_out), 1);
        chk("late_dep", 32'(dependency_out), 5);
        chk("late_opr1", opr1_out, 32'h55);

        // Both ports carry the same tag: ALU value is taken
        disp(4'd0, 1'b0, 32'd0, 32'd4, 1'b1, 1'b0, 3'd3, 3'd0, 3'd6);
        cyc(); clr();
        alu_ready_in = 1'b1; alu_dep_in = 3'd3; alu_value_in = 32'hA;
        lsb_ready_in = 1'b1; lsb_dep_in = 3'd3; lsb_value_in = 32'hB;
        cyc(); clr();
        cyc();
        chk("dual_valid", 32'(valid_out), 1);
        chk("dual_opr1", opr1_out, 32'hA);
        chk("dual_dep", 32'(dependency_out), 6);

        // Reset beats a low rdy_in and a flush
        disp(4'd1, 1'b0, 32'd1, 32'd1, 1'b1, 1'b0, 3'd2, 3'd0, 3'd0);
        cyc(); clr();
        rdy_in = 1'b0; rst_in = 1'b1; need_flush_in = 1'b1;
        cyc();
        rst_in = 1'b0; rdy_in = 1'b1; need_flush_in = 1'b0;
        chk("rst_prio_valid", 32'(valid_out), 0);
        chk("rst_prio_full", 32'(full_out), 0);
        chk("rst_prio_opr1", opr1_out, 0);
        chk("rst_prio_dep", 32'(dependency_out), 0);
        alu_ready_in = 1'b1; alu_dep_in = 3'd2; alu_value_in = 32'd9;
        cyc(); clr();
        got.delete();
        repeat (3) begin cyc(); rec(); end
        chk("rst_prio_no_issue", 32'(got.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
